// File: rtl/ext_mem_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// external-memory arbiter (ext_mem_arbiter and rr_channel_arb).
package ext_mem_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 20;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_NUM_REQ    = 2;
  localparam int ARB_IDX_WIDTH  = (ARB_NUM_REQ > 1) ? $clog2(ARB_NUM_REQ) : 1;

  // Requester indices
  localparam int REQ_CONV = 0;
  localparam int REQ_HOST = 1;

  typedef logic [ARB_ADDR_WIDTH-1:0] addr_t;
  typedef logic [ARB_DATA_WIDTH-1:0] data_t;
  typedef logic [ARB_NUM_REQ-1:0]    req_vec_t;
  typedef logic [ARB_IDX_WIDTH-1:0]  idx_t;

  // One-hot pick of the first requester strictly after 'last', wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic req_vec_t rr_pick(input req_vec_t req, input idx_t last);
    req_vec_t pick;
    idx_t     idx;
    pick = '0;
    for (int off = ARB_NUM_REQ; off >= 1; off--) begin
      idx = idx_t'((int'(last) + off) % ARB_NUM_REQ);
      if (req[idx]) pick = req_vec_t'(1) << idx;
    end
    return pick;
  endfunction

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic idx_t oh_to_idx(input req_vec_t oh);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < ARB_NUM_REQ; i++) begin
      if (oh[idx_t'(i)]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_channel_arb.sv
// rr_channel_arb: one arbitration channel (read or write) of ext_mem_arbiter.
// Holds the round-robin pointer and the bounded lock counter; the grant is
// combinational in the request cycle.
module rr_channel_arb
  import ext_mem_arb_pkg::*;
#(
  parameter int MAX_LOCK_CYCLES = 64
) (
  input  logic     clk,
  input  logic     arst_n_in,
  input  req_vec_t req,
  input  req_vec_t lock,
  output req_vec_t gnt
);

  localparam int CNT_WIDTH = $clog2(MAX_LOCK_CYCLES + 1);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_LOCK_CYCLES);

  idx_t last;
  cnt_t lock_cnt;
  logic hold;
  idx_t gnt_idx;
  cnt_t lock_cnt_next;

  // Holder keeps the channel while locked and under the limit; otherwise round-robin.
  // A non-zero counter implies 'last' was granted with lock in the previous cycle.
  always_comb begin
    // NOTE: every variable gets a value on every path so no latch is inferred.
    hold          = (lock_cnt != '0) && (lock_cnt != CNT_MAX) && req[last] && lock[last];
    gnt           = hold ? (req_vec_t'(1) << last) : rr_pick(req, last);
    gnt_idx       = oh_to_idx(gnt);
    lock_cnt_next = '0;
    if (hold) begin
      lock_cnt_next = lock_cnt + cnt_t'(1);
    end else if ((|gnt) && lock[gnt_idx]) begin
      lock_cnt_next = cnt_t'(1);
    end
  end

  // Pointer follows every grant; the counter tracks the current locked streak.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      last     <= idx_t'(ARB_NUM_REQ - 1);
      lock_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if (|gnt) last <= gnt_idx;
      lock_cnt <= lock_cnt_next;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares the external memory read and write ports between
// the convolution controller (index 0) and the host (index 1). Read and write
// channels arbitrate independently; read data returns one cycle after grant.
// Optional feature: define EXT_MEM_ARB_FWD_EN to return same-cycle write data
// on a read/write address collision instead of the old memory contents.
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH      = ARB_DATA_WIDTH,
  parameter int NUM_REQ         = ARB_NUM_REQ,
  parameter int MAX_LOCK_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 arst_n_in,
  input  logic [NUM_REQ-1:0]                   req_lock,
  input  logic [NUM_REQ-1:0]                   rd_req,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]                   rd_gnt,
  output logic [NUM_REQ-1:0]                   rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  input  logic [NUM_REQ-1:0]                   wr_req,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]                   wr_gnt,
  output logic [ADDR_WIDTH-1:0]                ext_mem_read_addr,
  input  logic [DATA_WIDTH-1:0]                ext_mem_qout,
  output logic [ADDR_WIDTH-1:0]                ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0]                ext_mem_din,
  output logic                                 ext_mem_write_en
);

  logic [ADDR_WIDTH-1:0] rd_addr_sel;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  rr_channel_arb #(
    .MAX_LOCK_CYCLES (MAX_LOCK_CYCLES)
  ) u_rd_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req       (rd_req),
    .lock      (req_lock),
    .gnt       (rd_gnt)
  );

  rr_channel_arb #(
    .MAX_LOCK_CYCLES (MAX_LOCK_CYCLES)
  ) u_wr_arb (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .req       (wr_req),
    .lock      (req_lock),
    .gnt       (wr_gnt)
  );

  // AND-OR select of the granted requester; all-zero when nothing is granted.
  always_comb begin
    rd_addr_sel = '0;
    wr_addr_sel = '0;
    wr_data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_addr_sel |= rd_addr[idx_t'(i)] & {ADDR_WIDTH{rd_gnt[idx_t'(i)]}};
      wr_addr_sel |= wr_addr[idx_t'(i)] & {ADDR_WIDTH{wr_gnt[idx_t'(i)]}};
      wr_data_sel |= wr_data[idx_t'(i)] & {DATA_WIDTH{wr_gnt[idx_t'(i)]}};
    end
  end

  assign ext_mem_read_addr  = (|rd_gnt) ? rd_addr_sel : rd_addr_q;
  assign ext_mem_write_addr = wr_addr_sel;
  assign ext_mem_din        = wr_data_sel;
  assign ext_mem_write_en   = |wr_gnt;

  // Hold the last granted read address; tag the word arriving next cycle.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rd_addr_q <= '0;
      rd_valid  <= '0;
    end else begin
      if (|rd_gnt) rd_addr_q <= rd_addr_sel;
      rd_valid <= rd_gnt;
    end
  end

`ifdef EXT_MEM_ARB_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Capture a same-cycle read/write collision so the new word is returned.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= (|rd_gnt) && (|wr_gnt) && (rd_addr_sel == wr_addr_sel);
      fwd_data <= wr_data_sel;
    end
  end

  assign rd_data = fwd_hit ? fwd_data : ext_mem_qout;
`else
  assign rd_data = ext_mem_qout;
`endif

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter (MAX_LOCK_CYCLES = 4): directed
// scenarios followed by randomized traffic, all compared against a
// behavioural model of the arbitration rules and of the memory contents.
module tb_ext_mem_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int NR   = 2;
  localparam int MAXL = 4;
`ifdef EXT_MEM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    arst_n_in;
  logic [NR-1:0]           req_lock, rd_req, wr_req;
  logic [NR-1:0]           rd_gnt, rd_valid, wr_gnt;
  logic [NR-1:0][AW-1:0]   rd_addr, wr_addr;
  logic [NR-1:0][DW-1:0]   wr_data;
  logic [DW-1:0]           rd_data, ext_mem_qout, ext_mem_din;
  logic [AW-1:0]           ext_mem_read_addr, ext_mem_write_addr;
  logic                    ext_mem_write_en;

  always #5 clk = ~clk;

  ext_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .NUM_REQ         (NR),
    .MAX_LOCK_CYCLES (MAXL)
  ) dut (
    .clk                (clk),
    .arst_n_in          (arst_n_in),
    .req_lock           (req_lock),
    .rd_req             (rd_req),
    .rd_addr            (rd_addr),
    .rd_gnt             (rd_gnt),
    .rd_valid           (rd_valid),
    .rd_data            (rd_data),
    .wr_req             (wr_req),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_gnt             (wr_gnt),
    .ext_mem_read_addr  (ext_mem_read_addr),
    .ext_mem_qout       (ext_mem_qout),
    .ext_mem_write_addr (ext_mem_write_addr),
    .ext_mem_din        (ext_mem_din),
    .ext_mem_write_en   (ext_mem_write_en)
  );

  // ---------------- external memory (environment) ----------------
  function automatic logic [DW-1:0] mem_init(int i);
    return (i == 7) ? 32'h1 : (32'h5A00_0000 | 32'(i));
  endfunction

  logic          preload_en;
  logic [DW-1:0] env_mem [256];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= mem_init(i);
    end else if (ext_mem_write_en) begin
      env_mem[ext_mem_write_addr[7:0]] <= ext_mem_din;
    end
    ext_mem_qout <= env_mem[ext_mem_read_addr[7:0]];
  end

  // ---------------- check bookkeeping ----------------
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Channel 0 = read, 1 = write.
  int            m_last   [2];  // most recent granted index (round-robin origin)
  int            m_prev   [2];  // index granted in the previous cycle, -1 if none
  int            m_streak [2];  // consecutive locked grants held by m_prev
  logic [AW-1:0] m_raddr_last;
  logic [NR-1:0] m_rdv_exp;
  logic [DW-1:0] m_rd_data_exp;
  logic [DW-1:0] m_mem [256];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_last[c]   = NR - 1;
      m_prev[c]   = -1;
      m_streak[c] = 0;
    end
    m_raddr_last  = '0;
    m_rdv_exp     = '0;
    m_rd_data_exp = '0;
  endtask

  function automatic logic [NR-1:0] onehot(int g);
    logic [NR-1:0] v;
    v = '0;
    if (g >= 0) v[g[0]] = 1'b1;
    return v;
  endfunction

  // Who gets the channel this cycle according to the arbitration rules.
  function automatic int model_pick(bit ch, logic [NR-1:0] req, logic [NR-1:0] lock);
    int p, k;
    p = m_prev[ch];
    if (p >= 0 && m_streak[ch] > 0 && m_streak[ch] < MAXL && req[p[0]] && lock[p[0]])
      return p;
    for (int off = 1; off <= NR; off++) begin
      k = (m_last[ch] + off) % NR;
      if (req[k[0]]) return k;
    end
    return -1;
  endfunction

  task automatic model_commit(bit ch, int g, logic [NR-1:0] lock);
    if (g < 0) begin
      m_prev[ch]   = -1;
      m_streak[ch] = 0;
    end else begin
      if (!lock[g[0]])
        m_streak[ch] = 0;
      else if (g == m_prev[ch] && m_streak[ch] > 0 && m_streak[ch] < MAXL)
        m_streak[ch] = m_streak[ch] + 1;
      else
        m_streak[ch] = 1;
      m_prev[ch] = g;
      m_last[ch] = g;
    end
  endtask

  // Observations sampled at the last negedge, for spec-constant checks.
  logic [NR-1:0] obs_rd_gnt, obs_wr_gnt, obs_rd_valid;
  logic [DW-1:0] obs_rd_data, obs_din;
  logic [AW-1:0] obs_waddr;
  logic          obs_we;

  // One clock cycle: inputs already applied; check at negedge, advance model.
  task automatic step(string tag);
    int            gr, gw;
    logic [NR-1:0] erg, ewg;
    @(negedge clk);
    obs_rd_gnt   = rd_gnt;
    obs_wr_gnt   = wr_gnt;
    obs_rd_valid = rd_valid;
    obs_rd_data  = rd_data;
    obs_we       = ext_mem_write_en;
    obs_waddr    = ext_mem_write_addr;
    obs_din      = ext_mem_din;
    gr  = model_pick(1'b0, rd_req, req_lock);
    gw  = model_pick(1'b1, wr_req, req_lock);
    erg = onehot(gr);
    ewg = onehot(gw);
    check({tag, ":rd_gnt"}, rd_gnt, erg);
    check({tag, ":wr_gnt"}, wr_gnt, ewg);
    check({tag, ":we"}, ext_mem_write_en, (gw >= 0));
    check({tag, ":raddr"}, ext_mem_read_addr, (gr >= 0) ? rd_addr[gr[0]] : m_raddr_last);
    if (gw >= 0) begin
      check({tag, ":waddr"}, ext_mem_write_addr, wr_addr[gw[0]]);
      check({tag, ":din"}, ext_mem_din, wr_data[gw[0]]);
    end
    check({tag, ":rd_valid"}, rd_valid, m_rdv_exp);
    if (m_rdv_exp != '0) check({tag, ":rd_data"}, rd_data, m_rd_data_exp);
    // advance the model to the next cycle
    m_rdv_exp = erg;
    if (gr >= 0) begin
      m_raddr_last = rd_addr[gr[0]];
      if (FWD && gw >= 0 && wr_addr[gw[0]] == rd_addr[gr[0]])
        m_rd_data_exp = wr_data[gw[0]];
      else
        m_rd_data_exp = m_mem[rd_addr[gr[0]][7:0]];
    end
    if (gw >= 0) m_mem[wr_addr[gw[0]][7:0]] = wr_data[gw[0]];
    model_commit(1'b0, gr, req_lock);
    model_commit(1'b1, gw, req_lock);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_lock = '0;
    rd_req   = '0;
    wr_req   = '0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n_in  = 1'b0;
    preload_en = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) m_mem[i] = mem_init(i);
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    preload_en = 1'b0;
    check("rst:rd_gnt", rd_gnt, 2'b00);
    check("rst:wr_gnt", wr_gnt, 2'b00);
    check("rst:rd_valid", rd_valid, 2'b00);
    check("rst:we", ext_mem_write_en, 1'b0);
    check("rst:raddr", ext_mem_read_addr, 20'h0);
    check("rst:waddr", ext_mem_write_addr, 20'h0);
    check("rst:din", ext_mem_din, 32'h0);
    @(posedge clk);
    #1;
    arst_n_in = 1'b1;

    // Both requesters read continuously: grants alternate starting with 0
    rd_req     = 2'b11;
    rd_addr[0] = 20'h10;
    rd_addr[1] = 20'h20;
    for (int i = 0; i < 6; i++) begin
      step("alt");
      check("alt:gnt_seq", obs_rd_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check("alt:valid_seq", obs_rd_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
        check("alt:data_seq", obs_rd_data, (i % 2 == 1) ? mem_init(16'h10) : mem_init(16'h20));
      end
    end
    rd_req = '0;

    // Host-only write
    wr_req     = 2'b10;
    wr_addr[1] = 20'h5;
    wr_data[1] = 32'hDEADBEEF;
    step("wr1");
    check("wr1:gnt", obs_wr_gnt, 2'b10);
    check("wr1:we", obs_we, 1'b1);
    check("wr1:addr", obs_waddr, 20'h5);
    check("wr1:din", obs_din, 32'hDEADBEEF);
    idle_inputs();

    // Requester 0 locked against a competing host read
    rd_req     = 2'b11;
    req_lock   = 2'b01;
    rd_addr[0] = 20'h10;
    rd_addr[1] = 20'h20;
    for (int i = 0; i < 10; i++) begin
      step("lock");
      check("lock:gnt_seq", obs_rd_gnt, (i % 5 == 4) ? 2'b10 : 2'b01);
    end
    idle_inputs();

    // Same-address read and write in one cycle
    rd_req     = 2'b01;
    rd_addr[0] = 20'h7;
    wr_req     = 2'b10;
    wr_addr[1] = 20'h7;
    wr_data[1] = 32'h2;
    step("coll");
    idle_inputs();
    step("coll_ret");
    check("coll:valid", obs_rd_valid, 2'b01);
    check("coll:data", obs_rd_data, FWD ? 32'h2 : 32'h1);

    // Reset the cycle after a read grant: in-flight rd_valid is dropped
    rd_req     = 2'b01;
    rd_addr[0] = 20'h33;
    step("pre_rst");
    idle_inputs();
    arst_n_in = 1'b0;
    #1;
    check("mrst:rd_valid", rd_valid, 2'b00);
    check("mrst:rd_gnt", rd_gnt, 2'b00);
    check("mrst:wr_gnt", wr_gnt, 2'b00);
    check("mrst:we", ext_mem_write_en, 1'b0);
    check("mrst:raddr", ext_mem_read_addr, 20'h0);
    @(posedge clk);
    #1;
    check("mrst:rd_valid_hold", rd_valid, 2'b00);
    arst_n_in = 1'b1;
    model_reset();
    rd_req     = 2'b11;
    wr_req     = 2'b11;
    rd_addr[0] = 20'h11;
    rd_addr[1] = 20'h22;
    wr_addr[0] = 20'h11;
    wr_addr[1] = 20'h22;
    wr_data[0] = 32'h1111_1111;
    wr_data[1] = 32'h2222_2222;
    step("post_rst");
    check("post_rst:valid", obs_rd_valid, 2'b00);
    check("post_rst:rd_gnt", obs_rd_gnt, 2'b01);
    check("post_rst:wr_gnt", obs_wr_gnt, 2'b01);
    idle_inputs();

    // Ten idle cycles, then the pointers must resume where they were
    for (int i = 0; i < 10; i++) begin
      step("idle");
      check("idle:rd_gnt", obs_rd_gnt, 2'b00);
      check("idle:wr_gnt", obs_wr_gnt, 2'b00);
      check("idle:we", obs_we, 1'b0);
    end
    rd_req = 2'b11;
    wr_req = 2'b11;
    step("resume");
    check("resume:rd_gnt", obs_rd_gnt, 2'b10);
    check("resume:wr_gnt", obs_wr_gnt, 2'b10);
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd_req   = NR'($urandom);
      wr_req   = NR'($urandom);
      req_lock = NR'($urandom);
      for (int r = 0; r < NR; r++) begin
        rd_addr[r] = AW'($urandom_range(0, 15));
        wr_addr[r] = AW'($urandom_range(0, 15));
        wr_data[r] = $urandom;
      end
      step("rand");
    end
    idle_inputs();
    step("drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
